// File: rtl/muldiv_sequencer.sv
// ---------------------------------------------------------------------------
// muldiv_sequencer
//   Multi-cycle controller and iterative datapath for the RV32M operation
//   codes (ALUoperation 5'b01000-5'b01111). It sits beside the single-cycle
//   ALU in EX. While a multiply or divide runs it holds the pipeline. It
//   returns the result together with a one-cycle done pulse. Every other
//   operation code passes through with stall low.
//
// Ports
//   clk           in   1     clock, rising edge
//   rst           in   1     synchronous, active-high reset
//   start         in   1     EX stage holds a valid instruction
//   flush         in   1     abort any operation in flight, no done pulse
//   ALUoperation  in   5     ALU operation code; [2:0] selects the M op
//   a, b          in   XLEN  rs1 / rs2 operands
//   stall         out  1     hold IF/ID/EX (combinational)
//   busy          out  1     sequencer not idle
//   done          out  1     one-cycle pulse, result valid
//   result        out  XLEN  product/quotient/remainder, held until next accept
// ---------------------------------------------------------------------------
module muldiv_sequencer #(
    parameter int XLEN    = 32,
    parameter int MUL_LAT = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            flush,
    input  logic [4:0]      ALUoperation,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            stall,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CNT_MAX = (XLEN > MUL_LAT) ? XLEN : MUL_LAT;
    localparam int CNT_W   = $clog2(CNT_MAX);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_DONE
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;

    // Latched operation context
    logic [XLEN-1:0]  a_q, b_q;
    logic [1:0]       op_q;      // op[1:0]; op[2] only steers the accept decision
    logic             q_neg;     // DIV with differing operand signs
    logic             r_neg;     // REM with a negative dividend

    // Restoring divider state: quo shifts the dividend out and quotient bits in
    logic [XLEN-1:0]  quo, rem, dvs;

    logic             is_md;
    logic [XLEN-1:0]  a_mag, b_mag;

    assign is_md = start & (ALUoperation[4:3] == 2'b01);
    assign stall = is_md & (state != S_DONE);
    assign busy  = (state != S_IDLE);

    // Signed divide ops (DIV, REM) have op[0]=0 and work on magnitudes.
    assign a_mag = (!ALUoperation[0] && a[XLEN-1]) ? -a : a;
    assign b_mag = (!ALUoperation[0] && b[XLEN-1]) ? -b : b;

    // ---------------------------------------------------------------- multiply
    // Extending both operands to 2*XLEN makes the low 2*XLEN product bits
    // correct for every signed/unsigned mix.
    // MULH (01) sign-extends both operands, MULHSU (10) only a, MULHU (11) neither.
    // For MUL (00) the extension does not affect the low word.
    logic              a_sign, b_sign;
    logic [2*XLEN-1:0] a_ext, b_ext, prod;

    assign a_sign = a_q[XLEN-1] & (op_q != 2'b11);
    assign b_sign = b_q[XLEN-1] & (op_q == 2'b01);
    assign a_ext  = {{XLEN{a_sign}}, a_q};
    assign b_ext  = {{XLEN{b_sign}}, b_q};
    assign prod   = a_ext * b_ext;

    // ---------------------------------------------------------------- divide
    logic [XLEN:0]   shifted;
    logic            ge;
    logic [XLEN-1:0] q_next, r_next, q_fin, r_fin;

    // NOTE: every combinational output gets a value on every path, so no latch is inferred.
    always_comb begin
        shifted = {rem, quo[XLEN-1]};
        ge      = (shifted >= {1'b0, dvs});
        // The true difference is smaller than dvs, so the low XLEN bits are exact.
        r_next  = ge ? (shifted[XLEN-1:0] - dvs) : shifted[XLEN-1:0];
        q_next  = {quo[XLEN-2:0], ge};
        q_fin   = q_neg ? -q_next : q_next;
        r_fin   = r_neg ? -r_next : r_next;
    end

    // ---------------------------------------------------------------- control
    // result and done are registered on the edge into DONE. A flush at that
    // edge therefore suppresses both the pulse and the result update.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the datapath registers are cleared too, so that no X
            // from an unused path reaches result.
            state  <= S_IDLE;
            cnt    <= '0;
            done   <= 1'b0;
            result <= '0;
            a_q    <= '0;
            b_q    <= '0;
            op_q   <= '0;
            q_neg  <= 1'b0;
            r_neg  <= 1'b0;
            quo    <= '0;
            rem    <= '0;
            dvs    <= '0;
        end else begin
            // NOTE: non-blocking assignments here; every register updates from
            // pre-edge values.
            done <= 1'b0;
            if (flush) begin
                state <= S_IDLE;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (is_md) begin
                            a_q   <= a;
                            b_q   <= b;
                            op_q  <= ALUoperation[1:0];
                            q_neg <= (ALUoperation[2:0] == 3'b100) & (a[XLEN-1] ^ b[XLEN-1]);
                            r_neg <= (ALUoperation[2:0] == 3'b110) & a[XLEN-1];
                            quo   <= a_mag;
                            rem   <= '0;
                            dvs   <= b_mag;
                            if (!ALUoperation[2]) begin
                                state <= S_MUL;
                                cnt   <= CNT_W'(MUL_LAT - 1);
                            end else if (b == '0) begin
                                // Divide by zero: quotient all ones, remainder is the dividend.
                                result <= ALUoperation[1] ? a : '1;
                                done   <= 1'b1;
                                state  <= S_DONE;
                            end else if (!ALUoperation[0] && a == MIN_NEG && b == '1) begin
                                // Signed overflow: quotient MIN_NEG, remainder 0.
                                result <= ALUoperation[1] ? '0 : MIN_NEG;
                                done   <= 1'b1;
                                state  <= S_DONE;
                            end else begin
                                state <= S_DIV;
                                cnt   <= CNT_W'(XLEN - 1);
                            end
                        end
                    end

                    S_MUL: begin
                        if (cnt == '0) begin
                            result <= (op_q == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
                            done   <= 1'b1;
                            state  <= S_DONE;
                        end else begin
                            cnt <= cnt - CNT_W'(1);
                        end
                    end

                    S_DIV: begin
                        quo <= q_next;
                        rem <= r_next;
                        if (cnt == '0) begin
                            result <= op_q[1] ? r_fin : q_fin;
                            done   <= 1'b1;
                            state  <= S_DONE;
                        end else begin
                            cnt <= cnt - CNT_W'(1);
                        end
                    end

                    S_DONE:  state <= S_IDLE;
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// ---------------------------------------------------------------------------
// tb_muldiv_sequencer
//   Self-checking bench for muldiv_sequencer (XLEN=32, MUL_LAT=2).
//   Expected results come from plain 64-bit arithmetic. Expected latency
//   comes from the operation class.
// ---------------------------------------------------------------------------
module tb_muldiv_sequencer;

    localparam int XLEN    = 32;
    localparam int MUL_LAT = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic            flush;
    logic [4:0]      ALUoperation;
    logic [XLEN-1:0] a, b;
    logic            stall, busy, done;
    logic [XLEN-1:0] result;

    int n_cmp = 0;
    int n_err = 0;

    muldiv_sequencer #(.XLEN(XLEN), .MUL_LAT(MUL_LAT)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .flush        (flush),
        .ALUoperation (ALUoperation),
        .a            (a),
        .b            (b),
        .stall        (stall),
        .busy         (busy),
        .done         (done),
        .result       (result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ------------------------------------------------------------ reference
    function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
        longint      sx, sy, ux, uy;
        logic [63:0] p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = longint'({32'b0, x});
        uy = longint'({32'b0, y});
        case (op)
            3'd0:    p = 64'(ux * uy);
            3'd1:    p = 64'(sx * sy);
            3'd2:    p = 64'(sx * uy);
            3'd3:    p = {32'b0, x} * {32'b0, y};
            3'd4:    p = (y == 0) ? 64'hFFFF_FFFF : 64'(sx / sy);
            3'd5:    p = (y == 0) ? 64'hFFFF_FFFF : 64'(ux / uy);
            3'd6:    p = (y == 0) ? {32'b0, x} : 64'(sx % sy);
            default: p = (y == 0) ? {32'b0, x} : 64'(ux % uy);
        endcase
        if (op == 3'd1 || op == 3'd2 || op == 3'd3) return p[63:32];
        return p[31:0];
    endfunction

    function automatic int ref_latency(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
        if (op < 3'd4) return MUL_LAT + 1;
        if (y == 0) return 1;
        if ((op == 3'd4 || op == 3'd6) && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 1;
        return XLEN + 1;
    endfunction

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 6))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h1;
            4:       return 32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    // ------------------------------------------------------------ drivers
    // Issue one M op. The instruction is held in EX while stalled, and the
    // operands are scrambled after accept. The instruction is also still
    // present in the done cycle, to show it is not accepted a second time.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
        logic [31:0] exp_r;
        int          exp_l;
        int          k;
        int          bad;
        exp_r = ref_result(op, x, y);
        exp_l = ref_latency(op, x, y);
        @(negedge clk);
        start        = 1'b1;
        ALUoperation = {2'b01, op};
        a            = x;
        b            = y;
        #1;
        check({tag, "_stall_accept"}, 32'(stall), 32'd1);
        @(posedge clk); #1;
        k   = 1;
        bad = 0;
        while (!done && k < 40) begin
            if (!stall || !busy) bad++;
            a = $urandom;
            b = $urandom;
            @(posedge clk); #1;
            k++;
        end
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_latency"}, 32'(k), 32'(exp_l));
        check({tag, "_result"}, result, exp_r);
        check({tag, "_stall_in_done"}, 32'(stall), 32'd0);
        check({tag, "_stall_while_busy"}, 32'(bad), 32'd0);
        @(posedge clk); #1;
        check({tag, "_not_reaccepted"}, 32'(busy), 32'd0);
        check({tag, "_single_pulse"}, 32'(done), 32'd0);
        start = 1'b0;
    endtask

    // ------------------------------------------------------------ main
    initial begin
        rst          = 1'b1;
        start        = 1'b0;
        flush        = 1'b0;
        ALUoperation = 5'b0;
        a            = '0;
        b            = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_stall", 32'(stall), 32'd0);
        check("reset_result", result, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Directed cases
        run_op("mul_7_m3", 3'd0, 32'd7, 32'hFFFF_FFFD);
        run_op("mulhu_m1", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("mulh_m1", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("mulhsu_m1", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("div_m7_2", 3'd4, 32'hFFFF_FFF9, 32'd2);
        run_op("rem_m7_2", 3'd6, 32'hFFFF_FFF9, 32'd2);
        run_op("divu_100_7", 3'd5, 32'd100, 32'd7);
        run_op("remu_100_7", 3'd7, 32'd100, 32'd7);
        run_op("divu_by0", 3'd5, 32'd5, 32'd0);
        run_op("remu_by0", 3'd7, 32'd5, 32'd0);
        run_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("divu_100_7b", 3'd5, 32'd100, 32'd7);

        // Flush during DIV at T+10: back to IDLE at T+11, no pulse, result held.
        begin
            int done_seen;
            done_seen = 0;
            @(negedge clk);
            start        = 1'b1;
            ALUoperation = 5'b01100;
            a            = 32'd1000;
            b            = 32'd3;
            @(posedge clk); #1;
            repeat (9) begin
                if (done) done_seen++;
                @(posedge clk); #1;
            end
            flush = 1'b1;
            start = 1'b0;
            @(posedge clk); #1;
            check("flush_busy", 32'(busy), 32'd0);
            check("flush_done", 32'(done | 1'(done_seen != 0)), 32'd0);
            check("flush_result_held", result, 32'd14);
            flush = 1'b0;
        end
        run_op("mul_after_flush", 3'd0, 32'd12345, 32'd678);

        // Flush in the accept cycle: nothing is accepted.
        @(negedge clk);
        start        = 1'b1;
        flush        = 1'b1;
        ALUoperation = 5'b01000;
        @(posedge clk); #1;
        check("flush_accept_busy", 32'(busy), 32'd0);
        start = 1'b0;
        flush = 1'b0;

        // Reset in the middle of a MUL.
        @(negedge clk);
        start        = 1'b1;
        ALUoperation = 5'b01011;
        a            = 32'hDEAD_BEEF;
        b            = 32'h1234_5678;
        @(posedge clk); #1;
        rst   = 1'b1;
        start = 1'b0;
        @(posedge clk); #1;
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_done", 32'(done), 32'd0);
        check("rst_mid_stall", 32'(stall), 32'd0);
        check("rst_mid_result", result, 32'd0);
        rst = 1'b0;

        // Non-M operation codes pass through.
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            start        = 1'b1;
            ALUoperation = (i == 0) ? 5'b00000 : 5'b11000;
            a            = 32'd9;
            b            = 32'd3;
            #1;
            check("pass_stall", 32'(stall), 32'd0);
            @(posedge clk); #1;
            check("pass_busy", 32'(busy), 32'd0);
            check("pass_done", 32'(done), 32'd0);
        end
        @(negedge clk);
        start = 1'b0;

        // Randomized operations against the reference.
        for (int i = 0; i < 60; i++) begin
            logic [2:0] op;
            op = 3'($urandom_range(0, 7));
            run_op($sformatf("rand%0d_op%0d", i, op), op, rand_operand(), rand_operand());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
